instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue.sv | 109 ++++++++++
 tb/tb_instr_prefetch_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Small FIFO between instruction fetch and decode. Each entry holds a fetched
// instruction word and the address it was fetched from. The head entry is
// driven combinationally from storage, so a word pushed on one edge is visible
// in the following cycle. There is no same-cycle bypass from input to output.
// A flush (taken branch/jump) empties the queue on the next edge.
//
// Parameters
//   DATA_W  instruction word width
//   PC_W    fetch address width
//   DEPTH   number of entries (power of two, >= 2)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   flush       synchronous discard of all entries; wins over push and pop
//   in_valid    fetch side presents in_instr/in_pc
//   in_instr    fetched instruction
//   in_pc       address of in_instr
//   in_ready    queue has a free entry (registered state only)
//   out_valid   head entry present
//   out_ready   decode consumes the head this cycle
//   instr_out   head instruction (0 when empty)
//   pc_out      head address (0 when empty)
//   is_c_instr  head instruction has its MSB set
//   count       number of occupied entries
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 15,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_instr,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            instr_out,
  output logic [PC_W-1:0]              pc_out,
  output logic                         is_c_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem_instr [DEPTH];
  logic [PC_W-1:0]   r_mem_pc    [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // in_ready looks only at the occupancy register, so a full queue refuses a
  // word even when the head is being consumed in the same cycle.
  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && w_in_ready && !flush;
  assign w_pop       = w_out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
      // natural overflow of the increment is the modulo-DEPTH wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; pointers and count alone define what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_pc[r_wr_ptr]    <= in_pc;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign count      = r_count;
  // Stale storage is masked so an empty queue always presents zeros.
  assign instr_out  = w_out_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign pc_out     = w_out_valid ? r_mem_pc[r_rd_ptr]    : '0;
  assign is_c_instr = w_out_valid && r_mem_instr[r_rd_ptr][DATA_W-1];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue. The stimulus process records every
// word it expects the queue to accept in a scoreboard queue; an independent
// monitor compares the head against the scoreboard whenever a pop happens.
module tb_instr_prefetch_queue;

  localparam int DW = 16;
  localparam int PW = 15;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_instr;
  logic [PW-1:0] in_pc;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] instr_out;
  logic [PW-1:0] pc_out;
  logic          is_c_instr;
  logic [2:0]    count;

  int errors = 0;
  int checks = 0;
  logic [DW+PW-1:0] sb [$];

  instr_prefetch_queue #(.DATA_W(DW), .PC_W(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .pc_out(pc_out), .is_c_instr(is_c_instr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish (time %0t, limit 50000)", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop takes place at the next rising edge whenever the head is
  // valid, decode is ready and no flush is pending.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !flush) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got instr=0x%0h pc=0x%0h expected no entry", instr_out, pc_out);
      end else begin
        if ({instr_out, pc_out} !== sb[0]) begin
          errors++;
          $display("FAIL pop_order: got instr=0x%0h pc=0x%0h expected instr=0x%0h pc=0x%0h",
                   instr_out, pc_out, sb[0][DW+PW-1:PW], sb[0][PW-1:0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus, called at posedge+1 and returning at the next
  // posedge+1. exp_acc is the hand-derived expectation for in_ready.
  task automatic step(input logic iv, input logic [DW-1:0] ins, input logic [PW-1:0] p,
                      input logic ordy, input logic fl, input logic exp_acc);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    if (fl) sb.delete();
    else if (iv && exp_acc) sb.push_back({ins, p});
    @(negedge clk);
    if (iv && !fl) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_instr_out", {16'd0, instr_out}, 32'd0);
    chk("rst_pc_out", {17'd0, pc_out}, 32'd0);
    chk("rst_is_c", {31'd0, is_c_instr}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic push, one-cycle latency, head contents
    step(1'b1, 16'h0005, 15'd0, 1'b0, 1'b0, 1'b1);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_instr", {16'd0, instr_out}, 32'h0005);
    step(1'b1, 16'hEC10, 15'd1, 1'b0, 1'b0, 1'b1);
    chk("two_count", {29'd0, count}, 32'd2);
    chk("two_instr", {16'd0, instr_out}, 32'h0005);
    chk("two_pc", {17'd0, pc_out}, 32'd0);
    chk("two_is_c", {31'd0, is_c_instr}, 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("c_head_is_c", {31'd0, is_c_instr}, 32'd1);
    chk("c_head_pc", {17'd0, pc_out}, 32'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // Pop request on an empty queue is ignored
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("empty_pop_count", {29'd0, count}, 32'd0);

    // Fill, reject fifth word, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 16'hA001 + 16'(i), 15'd16 + 15'(i), 1'b0, 1'b0, 1'b1);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 16'hBEEF, 15'd9, 1'b0, 1'b0, 1'b0);
    chk("full_reject_count", {29'd0, count}, 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("fill_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("fill_drain_instr", {16'd0, instr_out}, 32'd0);
    chk("fill_drain_pc", {17'd0, pc_out}, 32'd0);
    chk("fill_drain_is_c", {31'd0, is_c_instr}, 32'd0);

    // Steady state push+pop at count=2 across pointer wrap
    step(1'b1, 16'h1100, 15'd100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h1101, 15'd101, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h9200 + 16'(i), 15'd200 + 15'(i), 1'b1, 1'b0, 1'b1);
      chk("stream_count", {29'd0, count}, 32'd2);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_empty", {29'd0, count}, 32'd0);

    // Full queue: pop and in_valid together, word refused
    for (int i = 0; i < 4; i++) step(1'b1, 16'h3300 + 16'(i), 15'd300 + 15'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h3FFF, 15'd399, 1'b1, 1'b0, 1'b0);
    chk("full_pop_count", {29'd0, count}, 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("full_pop_drained", {29'd0, count}, 32'd0);

    // Flush with count=3 and concurrent push/pop
    for (int i = 0; i < 3; i++) step(1'b1, 16'h4400 + 16'(i), 15'd400 + 15'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h7777, 15'd777, 1'b1, 1'b1, 1'b1);
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 16'h1234, 15'd5, 1'b0, 1'b0, 1'b1);
    chk("post_flush_instr", {16'd0, instr_out}, 32'h1234);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_flush_empty", {29'd0, count}, 32'd0);

    // Asynchronous reset between edges
    step(1'b1, 16'h5500, 15'd50, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h5501, 15'd51, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_count", {29'd0, count}, 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    // Posedge just above happened after reset release but with no push; push now
    step(1'b1, 16'h6600, 15'd60, 1'b0, 1'b0, 1'b1);
    chk("first_push_count", {29'd0, count}, 32'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle_n(1);

    chk("sb_empty_at_end", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
